wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter that owns the register file's single write port. It merges results from the single-cycle ALU and the multi-cycle load unit into one registered write per cycle. Load results wait in a small FIFO, and a starvation guard ensures loads eventually drain. It sits between the execute/memory stages and the register file write port (write enable, write select, write data).

## Interface
- `MODE`, default 32: data width.
- `REG_NUMBER`, default 32: architectural register count.
- `FIFO_DEPTH`, default 4: load-result FIFO entries; must be a power of two, ≥2.
- `STARVE_MAX`, default 4: consecutive ALU wins tolerated while the FIFO is non-empty.
- Address width `ADDR_W` = $clog2(REG_NUMBER)+1, matching the register-file select ports.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result present; the ALU has no backpressure.
- `alu_rd`  in  ADDR_W  ALU destination register.
- `alu_data`  in  MODE  ALU result.
- `alu_stall`  out  1  registered; the ALU must hold `alu_valid` low in this cycle.
- `ld_valid`  in  1  load result offered.
- `ld_ready`  out  1  FIFO can accept; equals !full.
- `ld_rd`  in  ADDR_W  load destination register.
- `ld_data`  in  MODE  load result.
- `rf_write`  out  1  registered write enable to the register file.
- `rf_sel_write_reg`  out  ADDR_W  registered write address.
- `rf_data_in`  out  MODE  registered write data.
- `busy`  out  1  FIFO non-empty.
- Present only with `WB_BYPASS_EN`:
  - `rs1_sel`, `rs2_sel`  in  ADDR_W  decode read addresses.
  - `rf_rdata1`, `rf_rdata2`  in  MODE  register-file read data.
  - `fwd_data1`, `fwd_data2`  out  MODE  forwarded read data.

## Operation
- **Load enqueue.** A load is enqueued on an edge where `ld_valid && ld_ready`. It is held in the FIFO as {rd, data}.
- **Per-cycle arbitration, priority order:**
  1. If `alu_stall` is high and the FIFO is non-empty: pop the FIFO and issue the load.
  2. Otherwise, if `alu_valid`: issue the ALU result.
  3. Otherwise, if the FIFO is non-empty: pop and issue.
  4. Otherwise: issue nothing.
- **Dropped writes.** A write whose rd == 0 or rd ≥ REG_NUMBER is dropped. It is still consumed (ALU beat accepted or FIFO popped), but `rf_write` stays 0 for it.
- **Starvation counter.**
  - Increments when the ALU wins while the FIFO is non-empty.
  - Clears on any pop and whenever the FIFO is empty.
  - On the edge where the counter reaches STARVE_MAX, `alu_stall` registers 1 for exactly one cycle, then the counter clears.
- **Stall violation.** `alu_valid` high during `alu_stall` is a protocol violation. That ALU beat is discarded, and the simulation assertion `a_alu_stall_respected` fires.
- **FIFO full.** `ld_ready` is computed from the registered count only. A pop in the same cycle does not raise `ld_ready` until the next cycle.
- **Simultaneous events.** A simultaneous enqueue and pop on a non-full FIFO leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- **Reset.** `reset_n` low at any time, including mid-operation, discards FIFO contents and clears pointers, count and the starvation counter. Pending writes are lost. While reset is low:
  - `rf_write`=0, `rf_sel_write_reg`=0, `rf_data_in`=0.
  - `alu_stall`=0, `busy`=0, `ld_ready`=1.

## Timing
- **ALU path.** ALU result sampled at edge k → `rf_write` high during cycle k+1 → register file captures at edge k+1. Latency 1.
- **Load path.** Load accepted at edge k, FIFO idle, no ALU → popped at edge k+1 → `rf_write` high during cycle k+2. Minimum latency 2.
- **Write pulse.** `rf_write` is high for exactly one cycle per issued write. Back-to-back writes in consecutive cycles are allowed.
- **Stall cycle.** `alu_stall` rises at the edge after the STARVE_MAX-th consecutive ALU win. The pop happens at the end of the stall cycle.

## Configuration
- **`WB_BYPASS_EN` defined.** Forwarding ports exist. `fwd_dataN` = `rf_data_in` when `rf_write` && `rf_sel_write_reg` == `rsN_sel` && `rsN_sel` != 0; otherwise `rf_rdataN`. The path is purely combinational. It covers the cycle in which the register file still shows the old value.
- **`WB_BYPASS_EN` undefined.** The forwarding ports and logic are absent. Decode reads the register file directly.

## Structure
- **Package `wb_pkg`.**
  - Function `addr_w(REG_NUMBER)`.
  - Typedef `wb_entry_t` (packed struct {rd, data}), parameterised through localparams.
  - Enum `wb_src_e` {SRC_NONE, SRC_ALU, SRC_LD}, used for the arbitration select.
- **Sub-module `wb_fifo`.** Synchronous FIFO of `wb_entry_t` with push/pop/full/empty/count. Async active-low reset on pointers and count only.

## Test plan
- **Reset.** Assert `reset_n`=0 mid-traffic with 3 FIFO entries → `rf_write`=0, `busy`=0, `ld_ready`=1; no write issues after release.
- **ALU alone.** `alu_valid` with rd=5, data=0xDEADBEEF at edge k → `rf_write`=1, sel=5, data=0xDEADBEEF in cycle k+1 only.
- **Collision.** ALU rd=3 and load rd=7 accepted at the same edge k → rd3 written in cycle k+1, rd7 in cycle k+2.
- **Full and starvation.** Continuous ALU with 4 loads pushed → `ld_ready`=0 after the 4th. After 4 ALU wins, `alu_stall`=1 for one cycle, one load is written, then `ld_ready`=1 the next cycle.
- **Dropped addresses.** ALU rd=0 and load rd=40 → both consumed, `rf_write` never asserted, `busy` returns to 0.
- **Bypass (`WB_BYPASS_EN`).** `rf_write` with rd=9, data=0x55, and `rs1_sel`=9 → `fwd_data1`=0x55. With `rs1_sel`=0 → `fwd_data1` = `rf_rdata1`.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back arbiter: address-width helper,
// default-width write entry and the arbitration source select.
package wb_pkg;

   function automatic int unsigned addr_w(input int unsigned reg_number);
      return int'($clog2(reg_number)) + 1;
   endfunction

   localparam int unsigned WB_MODE       = 32;
   localparam int unsigned WB_REG_NUMBER = 32;
   localparam int unsigned WB_ADDR_W     = addr_w(WB_REG_NUMBER);

   typedef struct packed {
      logic [WB_ADDR_W-1:0] rd;
      logic [WB_MODE-1:0]   data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_LD   = 2'd2
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding pending load results. Storage is not reset; only
// pointers and occupancy count are cleared by the async active-low reset.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = wb_entry_t,
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  entry_t           wdata_i,
   input  logic             pop_i,
   output entry_t           rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Guard against over/underflow even if the caller misbehaves.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter owning the register-file write port: merges ALU results
// and FIFO-buffered load results with a starvation guard. Optional read
// forwarding is enabled with the WB_BYPASS_EN macro.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned MODE       = 32,
   parameter int unsigned REG_NUMBER = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned STARVE_MAX = 4,
   localparam int unsigned ADDR_W    = addr_w(REG_NUMBER)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [MODE-1:0]   alu_data,
   output logic              alu_stall,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_rd,
   input  logic [MODE-1:0]   ld_data,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_sel_write_reg,
   output logic [MODE-1:0]   rf_data_in,
   output logic              busy
`ifdef WB_BYPASS_EN
  ,input  logic [ADDR_W-1:0] rs1_sel,
   input  logic [ADDR_W-1:0] rs2_sel,
   input  logic [MODE-1:0]   rf_rdata1,
   input  logic [MODE-1:0]   rf_rdata2,
   output logic [MODE-1:0]   fwd_data1,
   output logic [MODE-1:0]   fwd_data2
`endif
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW    = $clog2(STARVE_MAX + 1);

   // Same layout as wb_entry_t, but sized by this instance's parameters.
   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [MODE-1:0]   data;
   } entry_t;

   entry_t            ld_entry;
   entry_t            alu_entry;
   entry_t            fifo_rdata;
   entry_t            issue;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              push;
   logic              pop;
   logic              rd_ok;
   wb_src_e           src;

   logic              rf_write_q, rf_write_d;
   logic [ADDR_W-1:0] rf_sel_q,   rf_sel_d;
   logic [MODE-1:0]   rf_data_q,  rf_data_d;
   logic              alu_stall_q, alu_stall_d;
   logic [SW-1:0]     starve_q,   starve_d;

   assign ld_entry  = '{rd: ld_rd,  data: ld_data};
   assign alu_entry = '{rd: alu_rd, data: alu_data};
   assign push      = ld_valid && !fifo_full;

   wb_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .push_i  (push),
      .wdata_i (ld_entry),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Arbitration, write-port next state and starvation tracking.
   always_comb begin
      src         = SRC_NONE;
      pop         = 1'b0;
      issue       = fifo_rdata;
      rd_ok       = 1'b0;
      rf_write_d  = 1'b0;
      rf_sel_d    = rf_sel_q;
      rf_data_d   = rf_data_q;
      alu_stall_d = 1'b0;
      starve_d    = '0;

      if (alu_stall_q && !fifo_empty) begin
         src = SRC_LD;
      end else if (alu_valid && !alu_stall_q) begin
         src = SRC_ALU;
      end else if (!fifo_empty) begin
         src = SRC_LD;
      end

      pop = (src == SRC_LD);
      if (src == SRC_ALU) begin
         issue = alu_entry;
      end

      // Out-of-range or r0 destinations are consumed but never written.
      rd_ok      = (issue.rd != '0) && (32'(issue.rd) < REG_NUMBER);
      rf_write_d = (src != SRC_NONE) && rd_ok;
      if (rf_write_d) begin
         rf_sel_d  = issue.rd;
         rf_data_d = issue.data;
      end

      if (!fifo_empty && (src == SRC_ALU)) begin
         if (starve_q == SW'(STARVE_MAX - 1)) begin
            alu_stall_d = 1'b1;
         end else begin
            starve_d = starve_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_write_q  <= 1'b0;
         rf_sel_q    <= '0;
         rf_data_q   <= '0;
         alu_stall_q <= 1'b0;
         starve_q    <= '0;
      end else begin
         rf_write_q  <= rf_write_d;
         rf_sel_q    <= rf_sel_d;
         rf_data_q   <= rf_data_d;
         alu_stall_q <= alu_stall_d;
         starve_q    <= starve_d;
      end
   end

   assign rf_write         = rf_write_q;
   assign rf_sel_write_reg = rf_sel_q;
   assign rf_data_in       = rf_data_q;
   assign alu_stall        = alu_stall_q;
   assign ld_ready         = !fifo_full;
   assign busy             = (fifo_count != '0);

`ifdef WB_BYPASS_EN
   // Covers the cycle where the register file still returns the old value.
   assign fwd_data1 = (rf_write_q && (rf_sel_q == rs1_sel) && (rs1_sel != '0))
                      ? rf_data_q : rf_rdata1;
   assign fwd_data2 = (rf_write_q && (rf_sel_q == rs2_sel) && (rs2_sel != '0))
                      ? rf_data_q : rf_rdata2;
`endif

   a_alu_stall_respected: assert property (
      @(posedge clk) disable iff (!reset_n) !(alu_stall_q && alu_valid)
   );

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes are queued by the stimulus
// and checked by a negedge monitor; side-band outputs are checked directly.
module tb_wb_arbiter;

   localparam int unsigned MODE   = 32;
   localparam int unsigned AW     = 6;

   typedef struct packed {
      logic [AW-1:0]   rd;
      logic [MODE-1:0] data;
   } wr_t;

   logic            clk;
   logic            reset_n;
   logic            alu_valid;
   logic [AW-1:0]   alu_rd;
   logic [MODE-1:0] alu_data;
   logic            alu_stall;
   logic            ld_valid;
   logic            ld_ready;
   logic [AW-1:0]   ld_rd;
   logic [MODE-1:0] ld_data;
   logic            rf_write;
   logic [AW-1:0]   rf_sel_write_reg;
   logic [MODE-1:0] rf_data_in;
   logic            busy;
`ifdef WB_BYPASS_EN
   logic [AW-1:0]   rs1_sel, rs2_sel;
   logic [MODE-1:0] rf_rdata1, rf_rdata2;
   logic [MODE-1:0] fwd_data1, fwd_data2;
`endif

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   wb_arbiter #(
      .MODE       (32),
      .REG_NUMBER (32),
      .FIFO_DEPTH (4),
      .STARVE_MAX (4)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .alu_valid        (alu_valid),
      .alu_rd           (alu_rd),
      .alu_data         (alu_data),
      .alu_stall        (alu_stall),
      .ld_valid         (ld_valid),
      .ld_ready         (ld_ready),
      .ld_rd            (ld_rd),
      .ld_data          (ld_data),
      .rf_write         (rf_write),
      .rf_sel_write_reg (rf_sel_write_reg),
      .rf_data_in       (rf_data_in),
      .busy             (busy)
`ifdef WB_BYPASS_EN
     ,.rs1_sel          (rs1_sel),
      .rs2_sel          (rs2_sel),
      .rf_rdata1        (rf_rdata1),
      .rf_rdata2        (rf_rdata2),
      .fwd_data1        (fwd_data1),
      .fwd_data2        (fwd_data2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write pulse must match the head of the expected queue.
   always @(negedge clk) begin : monitor
      wr_t e;
      if (reset_n === 1'b1 && rf_write === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: sel=%0d data=0x%0h, no write expected at %0t",
                     rf_sel_write_reg, rf_data_in, $time);
         end else begin
            e = exp_q.pop_front();
            if (rf_sel_write_reg !== e.rd || rf_data_in !== e.data) begin
               errors++;
               $display("FAIL write_data: got sel=%0d data=0x%0h expected sel=%0d data=0x%0h at %0t",
                        rf_sel_write_reg, rf_data_in, e.rd, e.data, $time);
            end
         end
      end
   end

   task automatic idle();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input logic [AW-1:0] rd, input logic [MODE-1:0] d);
      alu_valid = 1'b1; alu_rd = rd; alu_data = d;
   endtask

   task automatic ld(input logic [AW-1:0] rd, input logic [MODE-1:0] d);
      ld_valid = 1'b1; ld_rd = rd; ld_data = d;
   endtask

   task automatic exp_wr(input logic [AW-1:0] rd, input logic [MODE-1:0] d);
      exp_q.push_back('{rd: rd, data: d});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rf_write"}, rf_write, 0);
      check({tag, "_sel"},      rf_sel_write_reg, 0);
      check({tag, "_data"},     rf_data_in, 0);
      check({tag, "_stall"},    alu_stall, 0);
      check({tag, "_busy"},     busy, 0);
      check({tag, "_ld_ready"}, ld_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got time %0t expected < 200000", $time);
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      idle();
`ifdef WB_BYPASS_EN
      rs1_sel = '0; rs2_sel = '0; rf_rdata1 = '0; rf_rdata2 = '0;
`endif
      step(); step();
      check_reset_outputs("por");
      reset_n = 1'b1;
      step();

      // ALU alone: latency 1, single-cycle pulse
      alu(6'd5, 32'hDEADBEEF); exp_wr(6'd5, 32'hDEADBEEF);
      step(); idle();
      check("alu_write", rf_write, 1);
      check("alu_sel", rf_sel_write_reg, 5);
      check("alu_data", rf_data_in, 32'hDEADBEEF);
      step();
      check("alu_pulse_end", rf_write, 0);

      // Collision: ALU first, load one cycle later
      alu(6'd3, 32'h33); ld(6'd7, 32'h77);
      exp_wr(6'd3, 32'h33); exp_wr(6'd7, 32'h77);
      step(); idle();
      check("col_sel_alu", rf_sel_write_reg, 3);
      check("col_busy", busy, 1);
      step();
      check("col_write_ld", rf_write, 1);
      check("col_sel_ld", rf_sel_write_reg, 7);
      check("col_busy_drained", busy, 0);
      step();
      check("col_idle", rf_write, 0);

      // Dropped addresses: consumed without a write
      alu(6'd0, 32'h11); ld(6'd40, 32'h22);
      step(); idle();
      check("drop_alu_nowrite", rf_write, 0);
      check("drop_busy", busy, 1);
      step();
      check("drop_ld_nowrite", rf_write, 0);
      check("drop_busy_clear", busy, 0);
      step();

      // Full FIFO and starvation guard
      for (int i = 0; i < 4; i++) begin
         alu(6'(i + 1), 32'(32'hA0 + i));
         ld(6'(20 + i), 32'(32'hB0 + i));
         exp_wr(6'(i + 1), 32'(32'hA0 + i));
         step();
         check("fill_ld_ready", ld_ready, (i < 3) ? 1 : 0);
         check("fill_stall", alu_stall, 0);
      end
      alu(6'd5, 32'hA4); ld(6'd24, 32'hB4);
      exp_wr(6'd5, 32'hA4);
      for (int i = 0; i < 4; i++) exp_wr(6'(20 + i), 32'(32'hB0 + i));
      step(); idle();
      check("starve_stall", alu_stall, 1);
      check("starve_ld_ready_full", ld_ready, 0);
      check("starve_alu_sel", rf_sel_write_reg, 5);
      step();
      check("starve_stall_one_cycle", alu_stall, 0);
      check("starve_ld_ready_back", ld_ready, 1);
      check("starve_ld_write", rf_write, 1);
      check("starve_ld_sel", rf_sel_write_reg, 20);
      step(); step(); step(); step();
      check("starve_drained", busy, 0);
      check("starve_queue_empty", exp_q.size(), 0);

      // Reset mid-traffic with three FIFO entries
      alu(6'd11, 32'hC0); ld(6'd12, 32'hC1); exp_wr(6'd11, 32'hC0);
      step();
      alu(6'd13, 32'hC2); ld(6'd14, 32'hC3); exp_wr(6'd13, 32'hC2);
      step();
      alu(6'd15, 32'hC4); ld(6'd16, 32'hC5);
      step(); idle();
      check("rst_pre_busy", busy, 1);
      check("rst_pre_ld_ready", ld_ready, 1);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      step(); step();
      reset_n = 1'b1;
      repeat (6) step();
      check("rst_post_busy", busy, 0);
      check("rst_post_write", rf_write, 0);
      check("rst_queue_empty", exp_q.size(), 0);

`ifdef WB_BYPASS_EN
      // Forwarding from the in-flight write
      alu(6'd9, 32'h55); exp_wr(6'd9, 32'h55);
      step(); idle();
      rs1_sel = 6'd9; rs2_sel = 6'd9; rf_rdata1 = 32'h1111; rf_rdata2 = 32'h2222;
      #1;
      check("byp_fwd1_hit", fwd_data1, 32'h55);
      check("byp_fwd2_hit", fwd_data2, 32'h55);
      rs1_sel = 6'd0; rs2_sel = 6'd8;
      #1;
      check("byp_fwd1_r0", fwd_data1, 32'h1111);
      check("byp_fwd2_miss", fwd_data2, 32'h2222);
      step();
      rs1_sel = 6'd9;
      #1;
      check("byp_fwd1_nowrite", fwd_data1, 32'h1111);
`endif

      repeat (3) step();
      check("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
